// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the alu_pipe block.
package alu_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_AND    = 3'b011;
    localparam logic [2:0] OP_OR     = 3'b100;
    localparam logic [2:0] OP_MULT   = 3'b101;
    localparam logic [2:0] OP_LSHIFT = 3'b110;
    localparam logic [2:0] OP_RSHIFT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: the first partial product is taken on start,
// the remaining W-1 on the following cycles; done marks the final busy cycle.
module alu_mul_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= b[0] ? {{W{1'b0}}, a} : '0;
            mcand  <= {{W{1'b0}}, a} << 1;
            mplier <= b >> 1;
            cnt    <= CW'(W - 1);
            busy   <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end
        end
    end

    assign done    = busy && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with a 2*DATA_WIDTH registered result and flags.
// Build option ALU_PIPE_FAST_MUL_EN selects a single-cycle multiply.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   operand_a,
    input  logic [DATA_WIDTH-1:0]   operand_b,
    input  logic [2:0]              op_code,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] op_result,
    output logic                    flag_zero,
    output logic                    flag_carry,
    output logic                    flag_ovf
);

    localparam int W       = DATA_WIDTH;
    localparam int RW      = 2 * DATA_WIDTH;
    localparam int SHIFT_W = $clog2(DATA_WIDTH);

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            iter_mul;
    logic            load_alu;
    logic            load_mul;
    logic [RW-1:0]   a_ext;
    logic [RW-1:0]   b_ext;
    logic [RW-1:0]   alu_res;
    logic            alu_carry;
    logic            alu_ovf;
    logic            mul_busy;
    logic            mul_done;
    logic [RW-1:0]   mul_product;

`ifdef ALU_PIPE_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`else
    localparam logic FAST_MUL = 1'b0;
    logic mul_start;
    assign mul_start = accept && iter_mul;

    alu_mul_seq #(.W(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (operand_a),
        .b       (operand_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Valid/ready: a transfer happens on any cycle with valid && ready on that
    // port; valid never waits on ready, and the result is held until taken.
    assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign iter_mul  = !FAST_MUL && (op_code == OP_MULT);
    assign load_alu  = accept && !iter_mul;
    assign load_mul  = (state == ST_MUL_BUSY) && mul_busy && mul_done;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (accept) state_next = iter_mul ? ST_MUL_BUSY : ST_HOLD;
            ST_MUL_BUSY: if (load_mul) state_next = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    if (accept) state_next = iter_mul ? ST_MUL_BUSY : ST_HOLD;
                    else        state_next = ST_IDLE;
                end
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        a_ext     = {{W{1'b0}}, operand_a};
        b_ext     = {{W{1'b0}}, operand_b};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_code)
            OP_ADD: begin
                alu_res   = a_ext + b_ext;
                alu_carry = alu_res[W];
                alu_ovf   = (operand_a[W-1] == operand_b[W-1]) && (alu_res[W-1] != operand_a[W-1]);
            end
            OP_SUB: begin
                alu_res   = a_ext - b_ext;
                alu_carry = operand_a < operand_b;
                alu_ovf   = (operand_a[W-1] != operand_b[W-1]) && (alu_res[W-1] != operand_a[W-1]);
            end
            OP_XOR:    alu_res = a_ext ^ b_ext;
            OP_AND:    alu_res = a_ext & b_ext;
            OP_OR:     alu_res = a_ext | b_ext;
`ifdef ALU_PIPE_FAST_MUL_EN
            OP_MULT:   alu_res = a_ext * b_ext;
`else
            OP_MULT:   alu_res = '0;
`endif
            OP_LSHIFT: alu_res = a_ext << operand_b[SHIFT_W-1:0];
            OP_RSHIFT: alu_res = {{W{1'b0}}, operand_a >> operand_b[SHIFT_W-1:0]};
            default:   alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_result  <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (load_alu) begin
                op_result  <= alu_res;
                flag_zero  <= (alu_res == '0);
                flag_carry <= alu_carry;
                flag_ovf   <= alu_ovf;
            end else if (load_mul) begin
                op_result  <= mul_product;
                flag_zero  <= (mul_product == '0);
                flag_carry <= 1'b0;
                flag_ovf   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized checks of alu_pipe (DATA_WIDTH=8) against an
// arithmetic reference model and an expected-result queue.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic [2:0]  op_code;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] op_result;
    logic        flag_zero;
    logic        flag_carry;
    logic        flag_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [18:0] exp_q[$];

    alu_pipe #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .op_code    (op_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_result  (op_result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {zero, carry, ovf, result[15:0]}.
    function automatic logic [18:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia = int'(a);
        int ib = int'(b);
        int sa = (ia > 127) ? ia - 256 : ia;
        int sb = (ib > 127) ? ib - 256 : ib;
        int sh = ib % 8;
        int r  = 0;
        int s  = 0;
        bit c  = 1'b0;
        bit v  = 1'b0;
        logic [15:0] r16;
        case (op)
            3'd0: begin r = ia + ib; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            3'd1: begin r = ia - ib; c = (ia < ib); if (r < 0) r = r + 65536;
                        s = sa - sb; v = (s > 127) || (s < -128); end
            3'd2: r = ia ^ ib;
            3'd3: r = ia & ib;
            3'd4: r = ia | ib;
            3'd5: r = ia * ib;
            3'd6: r = ia * (1 << sh);
            default: r = ia / (1 << sh);
        endcase
        r16 = 16'(r);
        return {(r == 0), c, v, r16};
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
`ifdef ALU_PIPE_FAST_MUL_EN
        return (op == 3'd5) ? 1 : 1;
`else
        return (op == 3'd5) ? 9 : 1;
`endif
    endfunction

    function automatic logic [18:0] obs_now();
        return {flag_zero, flag_carry, flag_ovf, op_result};
    endfunction

    // Issues one op from IDLE with out_ready high, checks latency, stall and result.
    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [18:0] e;
        int lat;
        int stall;
        e = model(op, a, b);
        in_valid = 1'b1; op_code = op; operand_a = a; operand_b = b; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; stall = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) stall++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(op)));
        chk({tag, "_stall"}, 32'(stall), 32'(exp_lat(op) - 1));
        chk({tag, "_result"}, 32'(obs_now()), 32'(e));
        @(posedge clk); #1;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [18:0] e1;
        logic [18:0] e2;
        logic [18:0] held;
        bit          held_valid;
        int          guard;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operand_a = '0; operand_b = '0; op_code = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(op_result), 32'd0);
        chk("rst_flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(OP_ADD,    8'hFF, 8'h01, "add_carry");
        do_op(OP_SUB,    8'h03, 8'h05, "sub_borrow");
        do_op(OP_SUB,    8'h80, 8'h01, "sub_ovf");
        do_op(OP_SUB,    8'h05, 8'h05, "sub_zero");
        do_op(OP_ADD,    8'h7F, 8'h01, "add_ovf");
        do_op(OP_MULT,   8'hFF, 8'hFF, "mul_ff");
        do_op(OP_MULT,   8'h00, 8'h9A, "mul_zero");
        do_op(OP_LSHIFT, 8'h81, 8'h07, "lshift");
        do_op(OP_RSHIFT, 8'h80, 8'h03, "rshift");
        do_op(OP_XOR,    8'hA5, 8'h5A, "xor");
        do_op(OP_AND,    8'hF0, 8'h3C, "and");
        do_op(OP_OR,     8'h00, 8'h00, "or_zero");

        // Backpressure: result held for 5 cycles, then out and in transfer together.
        e1 = model(OP_ADD, 8'hC0, 8'h50);
        e2 = model(OP_SUB, 8'h03, 8'h05);
        in_valid = 1'b1; op_code = OP_ADD; operand_a = 8'hC0; operand_b = 8'h50; out_ready = 1'b0;
        @(posedge clk); #1;
        op_code = OP_SUB; operand_a = 8'h03; operand_b = 8'h05;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'(obs_now()), 32'(e1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_b2b_valid", 32'(out_valid), 32'd1);
        chk("bp_b2b_result", 32'(obs_now()), 32'(e2));
        @(posedge clk); #1;
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Randomized traffic with random backpressure, scored through exp_q.
        held = '0; held_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op_code   = 3'($urandom_range(0, 7));
            operand_a = 8'($urandom);
            operand_b = 8'($urandom);
            #1;
            if (held_valid) begin
                chk("sb_hold_valid", 32'(out_valid), 32'd1);
                chk("sb_hold_value", 32'(obs_now()), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("sb_unexpected_out", 32'd1, 32'd0);
                else                   chk("sb_result", 32'(obs_now()), 32'(exp_q.pop_front()));
            end
            held_valid = out_valid && !out_ready;
            held       = obs_now();
            if (in_valid && in_ready) exp_q.push_back(model(op_code, operand_a, operand_b));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0) && guard < 60) begin
            #1;
            if (out_valid) chk("sb_drain_result", 32'(obs_now()), 32'(exp_q.pop_front()));
            @(posedge clk); #1;
            guard++;
        end
        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        chk("sb_idle", 32'(out_valid), 32'd0);

        // Reset dropped during cycle 4 of a MULT.
        in_valid = 1'b1; op_code = OP_MULT; operand_a = 8'hFF; operand_b = 8'hFF; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", 32'(op_result), 32'd0);
        chk("arst_flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'd0);
        @(posedge clk); #1;
        chk("arst_still_idle", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(OP_ADD, 8'h01, 8'h01, "add_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
